// File: rtl/load_req_ctrl_if.sv
// Bus bundle for load_req_ctrl: EXU request, read-stage enable/completion,
// and WBU response channels. The controller connects through the slave
// modport; whoever drives requests and models the read stage uses master.
interface load_req_ctrl_if #(
    parameter int ADDR_W = 32
);
    // EXU -> controller load request
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [4:0]        req_rd;

    // controller <-> mem_read stage
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [63:0]       mem_rdata;

    // controller -> WBU result
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_data;
    logic [4:0]        resp_rd;
    logic [1:0]        resp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, req_rd,
        output req_ready,
        output mem_en, mem_addr,
        input  mem_valid, mem_rdata,
        output resp_valid, resp_data, resp_rd, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, req_rd,
        input  req_ready,
        input  mem_en, mem_addr,
        output mem_valid, mem_rdata,
        input  resp_valid, resp_data, resp_rd, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/load_req_ctrl.sv
// Load-side controller in front of the mem_read stage. Takes one load at a
// time, issues an 8-byte-aligned read, waits for completion (or times out),
// then returns the addressed bytes sign/zero-extended to 64 bits together
// with misaligned/timeout error flags.
module load_req_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    load_req_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [2:0]        r_addr_lo;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [4:0]        r_rd;
    logic [63:0]       r_resp_data;
    logic [1:0]        r_resp_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_misaligned;
    logic [63:0]       w_raw;
    logic [63:0]       w_ext_data;

    // Status outputs decode straight from the registered state.
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.mem_en     = (r_state == S_REQ);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_rd    = r_rd;
    assign bus.resp_err   = r_resp_err;

    // Misalignment check on the incoming request: low size bits must be zero.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_misaligned = 1'b0;
        unique case (bus.req_size)
            2'd0: w_misaligned = 1'b0;
            2'd1: w_misaligned = bus.req_addr[0];
            2'd2: w_misaligned = |bus.req_addr[1:0];
            2'd3: w_misaligned = |bus.req_addr[2:0];
        endcase
    end

    // Byte extraction: shift the addressed byte lane down, keep size bytes, extend.
    always_comb begin
        w_raw      = bus.mem_rdata >> {r_addr_lo, 3'b000};
        w_ext_data = w_raw;
        unique case (r_size)
            2'd0: w_ext_data = {{56{~r_unsigned & w_raw[7]}},  w_raw[7:0]};
            2'd1: w_ext_data = {{48{~r_unsigned & w_raw[15]}}, w_raw[15:0]};
            2'd2: w_ext_data = {{32{~r_unsigned & w_raw[31]}}, w_raw[31:0]};
            2'd3: w_ext_data = w_raw;
        endcase
    end

    // Control FSM with capture of request fields, result and timeout counter.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_addr_lo   <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_rd        <= '0;
            r_resp_data <= '0;
            r_resp_err  <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_mem_addr <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                        r_addr_lo  <= bus.req_addr[2:0];
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_rd       <= bus.req_rd;
                        r_cnt      <= '0;
                        if (w_misaligned) begin
                            r_resp_data <= '0;
                            r_resp_err  <= 2'b01;
                            r_state     <= S_RESP;
                        end else begin
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Completion beats the timeout terminal count.
                    if (bus.mem_valid) begin
                        r_resp_data <= w_ext_data;
                        r_resp_err  <= 2'b00;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 2'b10;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_req_ctrl.sv
// Self-checking bench for load_req_ctrl. Expected responses are pushed to a
// scoreboard queue when a load is issued and popped when the DUT presents
// resp_valid. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_load_req_ctrl;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic ACLK = 1'b0;
    logic ARESETn;

    always #5 ACLK = ~ACLK;

    load_req_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    load_req_ctrl #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference extraction built byte by byte.
    function automatic logic [63:0] model_data(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns, input logic [63:0] rdata);
        logic [63:0] v;
        int n;
        int lo;
        v  = '0;
        n  = 1 << size;
        lo = int'(addr[2:0]);
        for (int b = 0; b < n; b++) v[8*b +: 8] = rdata[8*(lo+b) +: 8];
        if (!uns && v[8*n-1]) begin
            for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] mask;
        mask = (32'd1 << size) - 32'd1;
        return (addr & mask) != 32'd0;
    endfunction

    task automatic push_exp(input logic [63:0] data, input logic [4:0] rd, input logic [1:0] err);
        exp_t e;
        e.data = data;
        e.rd   = rd;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                              input logic [4:0] rd, input logic [63:0] rdata);
        if (is_misaligned(addr, size)) push_exp(64'd0, rd, 2'b01);
        else                           push_exp(model_data(addr, size, uns, rdata), rd, 2'b00);
    endtask

    // Present a request in an IDLE cycle; returns 1 unit after the accept edge.
    task automatic start_req(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                             input logic [4:0] rd, input string name);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_rd       = rd;
        @(negedge ACLK);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s req_ready: got %b want 1", name, bus.req_ready);
        end
        @(posedge ACLK);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_rd       = 5'($urandom);
    endtask

    // Model the read stage: completion in REQ cycle 'delay' (1 = first cycle).
    task automatic mem_reply(input logic [31:0] exp_maddr, input int delay, input logic [63:0] rdata,
                             input string name);
        for (int c = 1; c <= delay; c++) begin
            if (c == delay) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = rdata;
            end else begin
                bus.mem_valid = 1'b0;
                bus.mem_rdata = {$urandom, $urandom};
            end
            @(negedge ACLK);
            n_checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_addr !== exp_maddr || bus.req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s req cycle %0d: mem_en=%b mem_addr=%h req_ready=%b, want 1 %h 0",
                         name, c, bus.mem_en, bus.mem_addr, bus.req_ready, exp_maddr);
            end
            @(posedge ACLK);
            #1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
    endtask

    // Pop the scoreboard when resp_valid shows; hold resp_ready low for ready_delay cycles.
    task automatic collect(input int ready_delay, input string name);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge ACLK);
        while (bus.resp_valid !== 1'b1 && waited < 30) begin
            @(negedge ACLK);
            waited++;
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: response with nothing expected", name);
            e.data = '0; e.rd = '0; e.err = '0;
        end else begin
            e = sb.pop_front();
        end
        n_checks++;
        if (waited != 0) begin
            n_errors++;
            $display("FAIL %s latency: resp_valid %0d cycles late (resp_valid=%b), want on time",
                     name, waited, bus.resp_valid);
        end
        if (bus.resp_valid !== 1'b1) begin
            @(posedge ACLK);
            #1;
            return;
        end
        n_checks++;
        if (bus.resp_data !== e.data || bus.resp_rd !== e.rd || bus.resp_err !== e.err ||
            bus.mem_en !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s resp: data=%h rd=%0d err=%b mem_en=%b req_ready=%b, want %h %0d %b 0 0",
                     name, bus.resp_data, bus.resp_rd, bus.resp_err, bus.mem_en, bus.req_ready,
                     e.data, e.rd, e.err);
        end
        for (int h = 0; h < ready_delay; h++) begin
            @(posedge ACLK);
            #1;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = {$urandom, $urandom};
            @(negedge ACLK);
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== e.data || bus.resp_rd !== e.rd ||
                bus.resp_err !== e.err || bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
                n_errors++;
                $display("FAIL %s hold %0d: valid=%b data=%h rd=%0d err=%b req_ready=%b mem_en=%b, want 1 %h %0d %b 0 0",
                         name, h, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_err,
                         bus.req_ready, bus.mem_en, e.data, e.rd, e.err);
            end
        end
        bus.mem_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge ACLK);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.req_rd       = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_rdata    = '0;
        bus.resp_ready   = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_addr !== '0 ||
            bus.resp_valid !== 1'b0 || bus.resp_data !== '0 || bus.resp_rd !== '0 ||
            bus.resp_err !== '0) begin
            n_errors++;
            $display("FAIL reset: req_ready=%b mem_en=%b mem_addr=%h resp_valid=%b data=%h rd=%0d err=%b, want 1 0 0 0 0 0 0",
                     bus.req_ready, bus.mem_en, bus.mem_addr, bus.resp_valid, bus.resp_data,
                     bus.resp_rd, bus.resp_err);
        end
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic test_lw();
        push_exp(64'hFFFF_FFFF_8765_4321, 5'd5, 2'b00);
        start_req(32'h8000_0004, 2'd2, 1'b0, 5'd5, "lw");
        mem_reply(32'h8000_0000, 3, 64'h8765_4321_1234_5678, "lw");
        collect(0, "lw");
    endtask

    task automatic test_byte();
        push_exp(64'h0000_0000_0000_00AB, 5'd9, 2'b00);
        start_req(32'h8000_0007, 2'd0, 1'b1, 5'd9, "lbu");
        mem_reply(32'h8000_0000, 2, 64'hAB00_0000_0000_0000, "lbu");
        collect(0, "lbu");
        push_exp(64'hFFFF_FFFF_FFFF_FFAB, 5'd10, 2'b00);
        start_req(32'h8000_0007, 2'd0, 1'b0, 5'd10, "lb");
        mem_reply(32'h8000_0000, 1, 64'hAB00_0000_0000_0000, "lb");
        collect(0, "lb");
        push_exp(64'hFFFF_FFFF_FFFF_8001, 5'd11, 2'b00);
        start_req(32'h0000_0012, 2'd1, 1'b0, 5'd11, "lh");
        mem_reply(32'h0000_0010, 2, 64'h0000_0000_8001_0000, "lh");
        collect(0, "lh");
    endtask

    task automatic test_misaligned();
        push_exp(64'd0, 5'd3, 2'b01);
        start_req(32'h8000_0003, 2'd1, 1'b0, 5'd3, "mis_lh");
        collect(2, "mis_lh");
        push_exp(64'd0, 5'd4, 2'b01);
        start_req(32'h8000_0002, 2'd2, 1'b1, 5'd4, "mis_lw");
        collect(1, "mis_lw");
        push_exp(64'd0, 5'd6, 2'b01);
        start_req(32'h8000_0004, 2'd3, 1'b0, 5'd6, "mis_ld");
        collect(0, "mis_ld");
    endtask

    task automatic test_timeout();
        push_exp(64'd0, 5'd12, 2'b10);
        start_req(32'h8000_0040, 2'd3, 1'b0, 5'd12, "timeout");
        for (int c = 1; c <= TIMEOUT; c++) begin
            bus.mem_rdata = {$urandom, $urandom};
            @(negedge ACLK);
            n_checks++;
            if (bus.mem_en !== 1'b1 || bus.resp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout cycle %0d: mem_en=%b resp_valid=%b, want 1 0",
                         c, bus.mem_en, bus.resp_valid);
            end
            @(posedge ACLK);
            #1;
        end
        collect(0, "timeout");
        push_exp(64'h0123_4567_89AB_CDEF, 5'd13, 2'b00);
        start_req(32'h8000_0048, 2'd3, 1'b0, 5'd13, "last_cycle");
        mem_reply(32'h8000_0048, TIMEOUT, 64'h0123_4567_89AB_CDEF, "last_cycle");
        collect(0, "last_cycle");
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        push_exp(64'h0000_0000_0000_5A5A, 5'd20, 2'b00);
        start_req(32'h0000_1000, 2'd1, 1'b1, 5'd20, "stall");
        mem_reply(32'h0000_1000, 1, 64'hFFFF_FFFF_FFFF_5A5A, "stall");
        collect(5, "stall");
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            push_exp(d, 5'(21 + i), 2'b00);
            start_req(32'h0000_2000 + 32'(8 * i), 2'd3, 1'b0, 5'(21 + i), "b2b_ld");
            mem_reply(32'h0000_2000 + 32'(8 * i), 1, d, "b2b_ld");
            collect(0, "b2b_ld");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        start_req(32'h8000_0100, 2'd2, 1'b0, 5'd7, "rst_mid");
        @(negedge ACLK);
        n_checks++;
        if (bus.mem_en !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid pre: mem_en=%b want 1", bus.mem_en);
        end
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (bus.mem_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
            bus.mem_addr !== '0 || bus.resp_data !== '0 || bus.resp_err !== '0) begin
            n_errors++;
            $display("FAIL rst_mid post: mem_en=%b req_ready=%b resp_valid=%b mem_addr=%h data=%h err=%b, want 0 1 0 0 0 0",
                     bus.mem_en, bus.req_ready, bus.resp_valid, bus.mem_addr, bus.resp_data, bus.resp_err);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge ACLK);
            #1;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = {$urandom, $urandom};
            @(negedge ACLK);
            n_checks++;
            if (bus.resp_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid idle %0d: resp_valid=%b mem_en=%b, want 0 0",
                         c, bus.resp_valid, bus.mem_en);
            end
        end
        @(posedge ACLK);
        #1;
        bus.mem_valid = 1'b0;
        d = 64'hDEAD_BEEF_CAFE_F00D;
        push_model(32'h8000_0104, 2'd2, 1'b1, 5'd8, d);
        start_req(32'h8000_0104, 2'd2, 1'b1, 5'd8, "rst_after");
        mem_reply(32'h8000_0100, 2, d, "rst_after");
        collect(0, "rst_after");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  s;
        logic        u;
        logic [4:0]  rd;
        logic [63:0] d;
        for (int i = 0; i < 16; i++) begin
            a  = $urandom;
            s  = 2'($urandom);
            u  = 1'($urandom);
            rd = 5'($urandom);
            d  = {$urandom, $urandom};
            if (i % 3 != 0) a = a & ~((32'd1 << s) - 32'd1);
            push_model(a, s, u, rd, d);
            start_req(a, s, u, rd, "rand");
            if (!is_misaligned(a, s)) begin
                mem_reply({a[31:3], 3'b000}, int'($urandom_range(1, TIMEOUT - 1)), d, "rand");
            end
            collect(int'($urandom_range(0, 2)), "rand");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_byte();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d responses missing, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
